// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the 8-entry register file between the core (A) and
// the debug/scan port (B), and sequences a commanded clear of all registers.
// Each transaction issues exactly one rf_rd or rf_wr pulse and returns a
// one-cycle ack with registered read data.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | sample clr_req / a_req / b_req, grant or start a clear
// ACCESS  | rf_rd or rf_wr high for this single cycle
// RESP    | ack to the granted requester, read data valid
// CLEAR   | rf_rst high for one cycle
// CDONE   | clr_done pulse
module regfile_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_idx1,
    input  logic [AW-1:0] a_idx2,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata1,
    output logic [DW-1:0] a_rdata2,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_idx1,
    input  logic [AW-1:0] b_idx2,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata1,
    output logic [DW-1:0] b_rdata2,
    input  logic          clr_req,
    output logic          clr_done,
    output logic          busy,
    output logic          rf_rst,
    output logic          rf_rd,
    output logic          rf_wr,
    output logic [AW-1:0] rf_rd_index1,
    output logic [AW-1:0] rf_rd_index2,
    output logic [AW-1:0] rf_wr_index,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata1,
    input  logic [DW-1:0] rf_rdata2
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_RESP   = 3'd2,
        S_CLEAR  = 3'd3,
        S_CDONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    // last_grant / gnt_b: 0 = A, 1 = B
    logic          last_grant;
    logic          gnt_b;
    logic          grant_a, grant_b;
    logic          sel_we;
    logic [AW-1:0] sel_idx1, sel_idx2;
    logic [DW-1:0] sel_wdata;

    // Grant decision in IDLE: clear wins, then single request, then round-robin on a tie
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == S_IDLE && !clr_req) begin
            if (a_req && b_req) begin
                if (last_grant) grant_a = 1'b1;
                else            grant_b = 1'b1;
            end else if (a_req) begin
                grant_a = 1'b1;
            end else if (b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    // Request fields of whichever side is being granted
    always_comb begin
        sel_we    = grant_b ? b_we    : a_we;
        sel_idx1  = grant_b ? b_idx1  : a_idx1;
        sel_idx2  = grant_b ? b_idx2  : a_idx2;
        sel_wdata = grant_b ? b_wdata : a_wdata;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clr_req)                 state_nxt = S_CLEAR;
                else if (grant_a || grant_b) state_nxt = S_ACCESS;
            end
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            S_CLEAR:  state_nxt = S_CDONE;
            S_CDONE:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Decoded outputs; rf_rst also follows rst so the register file clears with us
    always_comb begin
        busy     = (state != S_IDLE);
        a_ack    = (state == S_RESP) && !gnt_b;
        b_ack    = (state == S_RESP) &&  gnt_b;
        clr_done = (state == S_CDONE);
        rf_rst   = rst || (state == S_CLEAR);
    end

    // Register-file drive, grant bookkeeping and read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            gnt_b        <= 1'b0;
            rf_rd        <= 1'b0;
            rf_wr        <= 1'b0;
            rf_rd_index1 <= '0;
            rf_rd_index2 <= '0;
            rf_wr_index  <= '0;
            rf_wdata     <= '0;
            a_rdata1     <= '0;
            a_rdata2     <= '0;
            b_rdata1     <= '0;
            b_rdata2     <= '0;
        end else begin
            if (grant_a || grant_b) begin
                gnt_b        <= grant_b;
                last_grant   <= grant_b;
                rf_rd        <= !sel_we;
                rf_wr        <= sel_we;
                rf_rd_index1 <= sel_idx1;
                rf_rd_index2 <= sel_idx2;
                rf_wr_index  <= sel_idx1;
                rf_wdata     <= sel_wdata;
            end
            if (state == S_ACCESS) begin
                rf_rd <= 1'b0;
                rf_wr <= 1'b0;
                if (rf_rd) begin
                    if (gnt_b) begin
                        b_rdata1 <= rf_rdata1;
                        b_rdata2 <= rf_rdata2;
                    end else begin
                        a_rdata1 <= rf_rdata1;
                        a_rdata2 <= rf_rdata2;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x16 register file.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we, clr_req;
    logic [2:0]  a_idx1, a_idx2, b_idx1, b_idx2;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack, clr_done, busy, rf_rst, rf_rd, rf_wr;
    logic [15:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic [2:0]  rf_rd_index1, rf_rd_index2, rf_wr_index;
    logic [15:0] rf_wdata, rf_rdata1, rf_rdata2;

    int n_checks = 0;
    int n_errors = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    logic [15:0] regs [8];

    always #5 clk = ~clk;

    regfile_arbiter #(.DW(16), .AW(3)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_idx1(a_idx1), .a_idx2(a_idx2),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata1(a_rdata1), .a_rdata2(a_rdata2),
        .b_req(b_req), .b_we(b_we), .b_idx1(b_idx1), .b_idx2(b_idx2),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata1(b_rdata1), .b_rdata2(b_rdata2),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy), .rf_rst(rf_rst),
        .rf_rd(rf_rd), .rf_wr(rf_wr),
        .rf_rd_index1(rf_rd_index1), .rf_rd_index2(rf_rd_index2),
        .rf_wr_index(rf_wr_index), .rf_wdata(rf_wdata),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
    );

    // Register file model: synchronous clear and write, combinational read
    always @(posedge clk) begin
        if (rf_rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
        end else if (rf_wr) begin
            regs[rf_wr_index] <= rf_wdata;
        end
    end
    assign rf_rdata1 = regs[rf_rd_index1];
    assign rf_rdata2 = regs[rf_rd_index2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse counters and protocol invariants sampled mid-cycle
    always @(negedge clk) begin
        if (rf_rd) rd_cnt++;
        if (rf_wr) wr_cnt++;
        check("rd_wr_exclusive", {31'd0, rf_rd & rf_wr}, 32'd0);
        check("quiet_in_clear", {31'd0, rf_rst & ~rst & (rf_rd | rf_wr)}, 32'd0);
    end

    // Single transaction on A or B, expecting the ack two cycles after the request
    task automatic txn(input bit is_b, input bit we, input logic [2:0] i1,
                       input logic [2:0] i2, input logic [15:0] wd);
        int n;
        if (is_b) begin
            b_we = we; b_idx1 = i1; b_idx2 = i2; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_we = we; a_idx1 = i1; a_idx2 = i2; a_wdata = wd; a_req = 1'b1;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!(is_b ? b_ack : a_ack) && n < 8);
        check("txn_latency", n, 2);
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        a_req = 0; a_we = 0; a_idx1 = 0; a_idx2 = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_idx1 = 0; b_idx2 = 0; b_wdata = 0;
        clr_req = 0;
        repeat (2) tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_wr", rf_wr, 0);
        check("rst_idx", {rf_rd_index1, rf_rd_index2, rf_wr_index}, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_acks", {a_ack, b_ack, clr_done}, 0);
        check("rst_rdata", {a_rdata1 | a_rdata2 | b_rdata1 | b_rdata2}, 0);
        check("rst_rf_rst", rf_rst, 1);
        rst = 1'b0;
        #1;
        check("rf_rst_release", rf_rst, 0);

        // A write r3 = BEEF
        rd_cnt = 0; wr_cnt = 0;
        a_req = 1; a_we = 1; a_idx1 = 3; a_idx2 = 6; a_wdata = 16'hBEEF;
        tick();
        check("wr_access_busy", busy, 1);
        check("wr_access_rf_wr", rf_wr, 1);
        check("wr_access_rf_rd", rf_rd, 0);
        check("wr_index", rf_wr_index, 3);
        check("wr_wdata", rf_wdata, 16'hBEEF);
        check("wr_no_early_ack", a_ack, 0);
        tick();
        check("wr_a_ack", a_ack, 1);
        check("wr_b_ack", b_ack, 0);
        check("wr_rf_wr_drop", rf_wr, 0);
        check("wr_a_rdata_kept", a_rdata1, 0);
        a_req = 0;
        tick();
        check("wr_ack_pulse", a_ack, 0);
        check("wr_back_idle", busy, 0);
        check("wr_pulse_count", wr_cnt, 1);
        check("wr_no_read", rd_cnt, 0);

        // A read r3 / r0
        rd_cnt = 0; wr_cnt = 0;
        a_req = 1; a_we = 0; a_idx1 = 3; a_idx2 = 0;
        tick();
        check("rd_rf_rd", rf_rd, 1);
        check("rd_index1", rf_rd_index1, 3);
        check("rd_index2", rf_rd_index2, 0);
        tick();
        check("rd_a_ack", a_ack, 1);
        check("rd_a_rdata1", a_rdata1, 16'hBEEF);
        check("rd_a_rdata2", a_rdata2, 16'h0000);
        check("rd_b_rdata1", b_rdata1, 16'h0000);
        a_req = 0;
        tick();
        check("rd_pulse_count", rd_cnt, 1);
        check("rd_no_write", wr_cnt, 0);

        // Round-robin from reset: prime r1 via B, then hold both requests
        rst = 1; tick(); rst = 0;
        txn(1'b1, 1'b1, 3'd1, 3'd0, 16'h1111);
        a_we = 0; a_idx1 = 1; a_idx2 = 0;
        b_we = 0; b_idx1 = 0; b_idx2 = 1;
        a_req = 1; b_req = 1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(a_ack | b_ack) && n < 8);
            check("rr_one_ack", {31'd0, a_ack ^ b_ack}, 1);
            check("rr_b_turn", b_ack, k % 2);
            if (k == 0) check("rr_first_latency", n, 2);
            else        check("rr_spacing", n, 3);
            if (k % 2 == 1) check("rr_b_rdata2", b_rdata2, 16'h1111);
            else            check("rr_a_rdata1", a_rdata1, 16'h1111);
        end
        a_req = 0; b_req = 0;
        tick();
        check("rr_idle", busy, 0);

        // Clear wins over a simultaneous read; read afterwards sees zeros
        txn(1'b0, 1'b1, 3'd5, 3'd0, 16'h1234);
        txn(1'b0, 1'b0, 3'd5, 3'd1, 16'h0000);
        check("pre_clr_r5", a_rdata1, 16'h1234);
        check("pre_clr_r1", a_rdata2, 16'h1111);
        clr_req = 1; a_req = 1; a_we = 0; a_idx1 = 5; a_idx2 = 1;
        tick();
        check("clr_rf_rst", rf_rst, 1);
        check("clr_busy", busy, 1);
        check("clr_no_rd", rf_rd, 0);
        check("clr_no_ack", a_ack, 0);
        clr_req = 0;
        tick();
        check("clr_done", clr_done, 1);
        check("clr_rf_rst_1cyc", rf_rst, 0);
        tick();
        check("clr_done_pulse", clr_done, 0);
        check("clr_then_idle", busy, 0);
        tick();
        check("post_clr_rd", rf_rd, 1);
        check("post_clr_idx", rf_rd_index1, 5);
        tick();
        check("post_clr_ack", a_ack, 1);
        check("post_clr_r5", a_rdata1, 16'h0000);
        check("post_clr_r1", a_rdata2, 16'h0000);
        a_req = 0;
        tick();

        // rst during a B write in ACCESS aborts without an ack
        check("pre_abort_b_rdata2", b_rdata2, 16'h1111);
        b_req = 1; b_we = 1; b_idx1 = 2; b_wdata = 16'h5555;
        tick();
        check("abort_access_wr", rf_wr, 1);
        rst = 1;
        #1;
        check("abort_rf_rst_comb", rf_rst, 1);
        tick();
        check("abort_no_ack", b_ack, 0);
        check("abort_busy", busy, 0);
        check("abort_rf_wr", rf_wr, 0);
        check("abort_rdata", {a_rdata1 | a_rdata2 | b_rdata1 | b_rdata2}, 0);
        rst = 0; b_req = 0;
        tick();
        check("abort_stays_idle", {busy, b_ack, rf_wr}, 0);

        // Quiet idle
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", {rf_rd, rf_wr, busy, a_ack, b_ack, clr_done}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
